// File: rtl/fwd_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_if
//   Bundles the decode-side signals of the operand forwarding / load-use
//   hazard unit into one interface.
//
//   Signals (decode/ALU side -> unit):
//     issue_wr_en, issue_load, issue_rd   instruction being issued from decode
//     rd_addr[NUM_READ]                   source register per operand port
//     rf_data[NUM_READ]                   register-file read data per port
//     stage_data[DEPTH]                   result held in each tracked stage
//     hold, flush                         pipeline freeze / squash
//   Signals (unit -> ALU side):
//     fwd_data[NUM_READ], fwd_sel[NUM_READ], stall
//     fwd_count, stall_count              only with FWD_HAZARD_STATS_EN
//
//   Modports: master drives the request side (decode stage / testbench),
//   slave is the hazard unit itself.
// ---------------------------------------------------------------------------
interface fwd_hazard_if #(
  parameter int WIDTH    = 64,
  parameter int REG_ADDR = 5,
  parameter int DEPTH    = 2,
  parameter int NUM_READ = 2
);

  logic                               issue_wr_en;
  logic                               issue_load;
  logic [REG_ADDR-1:0]                issue_rd;
  logic [NUM_READ-1:0][REG_ADDR-1:0]  rd_addr;
  logic [NUM_READ-1:0][WIDTH-1:0]     rf_data;
  logic [DEPTH-1:0][WIDTH-1:0]        stage_data;
  logic                               hold;
  logic                               flush;

  logic [NUM_READ-1:0][WIDTH-1:0]     fwd_data;
  logic [NUM_READ-1:0][2:0]           fwd_sel;
  logic                               stall;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]                        fwd_count;
  logic [31:0]                        stall_count;

  modport master (
    output issue_wr_en, issue_load, issue_rd, rd_addr, rf_data,
           stage_data, hold, flush,
    input  fwd_data, fwd_sel, stall, fwd_count, stall_count
  );

  modport slave (
    input  issue_wr_en, issue_load, issue_rd, rd_addr, rf_data,
           stage_data, hold, flush,
    output fwd_data, fwd_sel, stall, fwd_count, stall_count
  );
`else
  modport master (
    output issue_wr_en, issue_load, issue_rd, rd_addr, rf_data,
           stage_data, hold, flush,
    input  fwd_data, fwd_sel, stall
  );

  modport slave (
    input  issue_wr_en, issue_load, issue_rd, rd_addr, rf_data,
           stage_data, hold, flush,
    output fwd_data, fwd_sel, stall
  );
`endif

endinterface

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding and load-use hazard detection for the pipelined CPU.
//   Sits between register-file read (decode) and the ALU operand inputs.
//   Keeps a small tracker of the last DEPTH issued instructions
//   (write-enable, load flag, destination register), forwards the youngest
//   in-flight result that matches each operand port, and raises a one-cycle
//   load-use stall (with a bubble injected into the tracker) when an operand
//   depends on a load that is still in the ALU stage.
//
//   Ports:
//     clk    clock, all state updates on posedge
//     reset  synchronous, active-low reset
//     bus    fwd_hazard_if.slave (issue info, read ports, stage results,
//            hold/flush in; fwd_data/fwd_sel/stall out)
//
//   Parameters: WIDTH, REG_ADDR, ZERO_REG, DEPTH (1..4), NUM_READ.
//
//   Optional feature macro FWD_HAZARD_STATS_EN: adds saturating 32-bit
//   fwd_count and stall_count outputs on the interface. Without it no
//   counters exist.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int WIDTH    = 64,
  parameter int REG_ADDR = 5,
  parameter int ZERO_REG = 31,
  parameter int DEPTH    = 2,
  parameter int NUM_READ = 2
) (
  input  logic         clk,
  input  logic         reset,
  fwd_hazard_if.slave  bus
);

  localparam logic [REG_ADDR-1:0] ZERO_IDX = REG_ADDR'(ZERO_REG);

  // One tracked in-flight instruction; index 0 of the tracker is youngest.
  typedef struct packed {
    logic                v_wr;
    logic                load;
    logic [REG_ADDR-1:0] rd;
  } entry_t;

  entry_t [DEPTH-1:0]                 trk;
  entry_t [DEPTH-1:0]                 trk_next;
  entry_t                             issue_entry;

  logic [NUM_READ-1:0][DEPTH-1:0]     hit;
  logic [NUM_READ-1:0][2:0]           sel_c;
  logic [NUM_READ-1:0][WIDTH-1:0]     data_c;
  logic                               stall_c;
  logic                               any_fwd;

  // Match matrix. The zero register is excluded on the read side as well, so
  // a stray tracker entry can never make reads of the zero register forward.
  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        hit[p][k] = trk[k].v_wr &&
                    (trk[k].rd == bus.rd_addr[p]) &&
                    (bus.rd_addr[p] != ZERO_IDX);
      end
    end
  end

  // Operand mux. Scanning from oldest to youngest lets the youngest match
  // overwrite any older one, so an older writer is never visible past a
  // younger writer of the same register.
  always_comb begin
    sel_c  = '0;
    data_c = bus.rf_data;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[p][k]) begin
          sel_c[p]  = 3'(k + 1);
          data_c[p] = bus.stage_data[k];
        end
      end
    end
  end

  // Load-use hazard: the ALU-stage value of a load is only its address,
  // so any port depending on a load in entry 0 must wait one cycle.
  always_comb begin
    stall_c = 1'b0;
    any_fwd = 1'b0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (hit[p][0] && trk[0].load) begin
        stall_c = 1'b1;
      end
      if (sel_c[p] != 3'd0) begin
        any_fwd = 1'b1;
      end
    end
  end

  assign bus.fwd_sel  = sel_c;
  assign bus.fwd_data = data_c;
  assign bus.stall    = stall_c;

  // Next tracker contents for an advancing cycle. A stalled cycle pushes an
  // all-zero bubble so the waiting load moves on to entry 1 and is then
  // forwarded from stage_data[1]. Writes to the zero register are recorded
  // as non-writing so they can never match.
  always_comb begin
    issue_entry.v_wr = bus.issue_wr_en && (bus.issue_rd != ZERO_IDX);
    issue_entry.load = bus.issue_load;
    issue_entry.rd   = bus.issue_rd;

    trk_next = trk;
    trk_next[0] = stall_c ? entry_t'('0) : issue_entry;
    for (int k = 1; k < DEPTH; k++) begin
      trk_next[k] = trk[k-1];
    end
  end

  // Tracker register: reset, then flush (which overrides hold and stall),
  // then hold freezes everything, otherwise advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trk <= '0;
    end else if (bus.flush) begin
      trk <= '0;
    end else if (!bus.hold) begin
      trk <= trk_next;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt;
  logic [31:0] stall_cnt;

  // Forward events count only on cycles that actually advance with a
  // forwarded operand and no stall; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_cnt <= '0;
    end else if (!bus.hold && !bus.flush && !stall_c && any_fwd &&
                 (fwd_cnt != 32'hFFFF_FFFF)) begin
      fwd_cnt <= fwd_cnt + 32'd1;
    end
  end

  // Stall cycles count whenever the pipeline is not held, including the
  // cycle in which a flush squashes the stalling load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!bus.hold && stall_c && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.fwd_count   = fwd_cnt;
  assign bus.stall_count = stall_cnt;
`else
  // any_fwd only feeds the statistics counters.
  logic unused_any_fwd;
  assign unused_any_fwd = any_fwd;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Self-checking bench for fwd_hazard_unit (default parameters). A model of
//   in-flight instructions kept as a plain queue (youngest at the front)
//   predicts fwd_sel/fwd_data/stall every cycle; directed scenarios pin the
//   model with literal expectations, then randomized traffic follows.
//   Honours FWD_HAZARD_STATS_EN for the counter outputs.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int WIDTH    = 64;
  localparam int REG_ADDR = 5;
  localparam int ZERO_REG = 31;
  localparam int DEPTH    = 2;
  localparam int NUM_READ = 2;

  logic clk;
  logic reset;

  fwd_hazard_if #(
    .WIDTH(WIDTH), .REG_ADDR(REG_ADDR), .DEPTH(DEPTH), .NUM_READ(NUM_READ)
  ) bus ();

  fwd_hazard_unit #(
    .WIDTH(WIDTH), .REG_ADDR(REG_ADDR), .ZERO_REG(ZERO_REG),
    .DEPTH(DEPTH), .NUM_READ(NUM_READ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: queue of in-flight instructions, youngest first, at most DEPTH.
  typedef struct {
    bit writes;
    bit is_load;
    int rd;
  } inflight_t;

  inflight_t inflight[$];
  bit        m_valid = 0;
  longint    m_fwd_cnt = 0;
  longint    m_stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source the model picks for a port: 0 = register file, k+1 = age k.
  function automatic int m_sel(int p);
    int a;
    a = int'(bus.rd_addr[p]);
    if (a == ZERO_REG) return 0;
    for (int k = 0; k < inflight.size(); k++) begin
      if (inflight[k].writes && inflight[k].rd == a) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    if (inflight.size() == 0 || !inflight[0].is_load) return 0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (m_sel(p) == 1) return 1;
    end
    return 0;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    bit        st;
    bit        fw;
    inflight_t e;
    st = m_stall();
    fw = 0;
    for (int p = 0; p < NUM_READ; p++) if (m_sel(p) != 0) fw = 1;
    if (reset === 1'b0) begin
      inflight.delete();
      m_valid     = 1;
      m_fwd_cnt   = 0;
      m_stall_cnt = 0;
    end else if (m_valid) begin
      if (!bus.hold && st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (!bus.hold && !bus.flush && !st && fw && m_fwd_cnt < 64'hFFFF_FFFF) m_fwd_cnt++;
      if (bus.flush) begin
        inflight.delete();
      end else if (!bus.hold) begin
        if (st) begin
          e.writes = 0; e.is_load = 0; e.rd = 0;
        end else begin
          e.writes  = bus.issue_wr_en && (int'(bus.issue_rd) != ZERO_REG);
          e.is_load = bus.issue_load;
          e.rd      = int'(bus.issue_rd);
        end
        inflight.push_front(e);
        if (inflight.size() > DEPTH) void'(inflight.pop_back());
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    int          s;
    bit          st;
    logic [63:0] exp_d;
    if (m_valid) begin
      st = m_stall();
      chk("stall", 64'(bus.stall), 64'(st));
      for (int p = 0; p < NUM_READ; p++) begin
        s = m_sel(p);
        chk($sformatf("sel[%0d]", p), 64'(bus.fwd_sel[p]), 64'(s));
        exp_d = (s == 0) ? bus.rf_data[p] : bus.stage_data[s-1];
        if (!(st && s == 1)) chk($sformatf("data[%0d]", p), bus.fwd_data[p], exp_d);
      end
`ifdef FWD_HAZARD_STATS_EN
      chk("fwd_count",   64'(bus.fwd_count),   64'(m_fwd_cnt));
      chk("stall_count", 64'(bus.stall_count), 64'(m_stall_cnt));
`endif
    end
  end

  task automatic applyStimulus(
    input logic        rst, wr, ld,
    input logic [4:0]  rd, a0, a1,
    input logic [63:0] r0, r1, s0, s1,
    input logic        hld, fl
  );
    @(posedge clk);
    #1;
    reset           = rst;
    bus.issue_wr_en = wr;
    bus.issue_load  = ld;
    bus.issue_rd    = rd;
    bus.rd_addr[0]  = a0;
    bus.rd_addr[1]  = a1;
    bus.rf_data[0]  = r0;
    bus.rf_data[1]  = r1;
    bus.stage_data[0] = s0;
    bus.stage_data[1] = s1;
    bus.hold        = hld;
    bus.flush       = fl;
  endtask

  task automatic settle();
    #3;
  endtask

  // Literal expectation for one port; data is skipped on stalled cycles.
  task automatic checkOutput(input string name, input int p, input logic [2:0] esel,
                             input logic [63:0] edata, input logic estall);
    chk({name, "_sel"},   64'(bus.fwd_sel[p]), 64'(esel));
    chk({name, "_stall"}, 64'(bus.stall),      64'(estall));
    if (!estall) chk({name, "_data"}, bus.fwd_data[p], edata);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 9);
    if (r >= 8) return 5'(ZERO_REG);
    return 5'(r);
  endfunction

  initial begin
    reset           = 1'b0;
    bus.issue_wr_en = 1'b0;
    bus.issue_load  = 1'b0;
    bus.issue_rd    = '0;
    bus.rd_addr     = '0;
    bus.rf_data     = '0;
    bus.stage_data  = '0;
    bus.hold        = 1'b0;
    bus.flush       = 1'b0;

    // Reset for two cycles, then check the register-file path.
    applyStimulus(0, 0, 0, 0, 1, 2, 8, 16, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 8, 16, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 8, 16, 0, 0, 0, 0);
    settle();
    checkOutput("t1_p0", 0, 3'd0, 64'd8, 1'b0);
    checkOutput("t1_p1", 1, 3'd0, 64'd16, 1'b0);

    // ADD X3 forwarded from stage 0, then from stage 1.
    applyStimulus(1, 1, 0, 3, 1, 2, 8, 16, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 3, 2, 8, 16, 24, 0, 0, 0);
    settle();
    checkOutput("t2_s0", 0, 3'd1, 64'd24, 1'b0);
    applyStimulus(1, 0, 0, 0, 3, 2, 8, 16, 0, 24, 0, 0);
    settle();
    checkOutput("t2_s1", 0, 3'd2, 64'd24, 1'b0);

    // ADD X3 then SUB X3: both ports pick the younger writer.
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 3, 3, 5, 6, 64'h111, 64'h222, 0, 0);
    settle();
    checkOutput("t3_p0", 0, 3'd1, 64'h111, 1'b0);
    checkOutput("t3_p1", 1, 3'd1, 64'h111, 1'b0);

    // LDUR X5, dependent read stalls once, then forwards from stage 1.
    applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 5, 1, 9, 10, 64'h55, 0, 0, 0);
    settle();
    checkOutput("t4_stall", 0, 3'd1, 64'd0, 1'b1);
    applyStimulus(1, 0, 0, 0, 5, 1, 9, 10, 0, 100, 0, 0);
    settle();
    checkOutput("t4_fwd", 0, 3'd2, 64'd100, 1'b0);

    // ADD X31 is never forwarded.
    applyStimulus(1, 1, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 31, 31, 77, 78, 1, 2, 0, 0);
    settle();
    checkOutput("t5_p0", 0, 3'd0, 64'd77, 1'b0);
    checkOutput("t5_p1", 1, 3'd0, 64'd78, 1'b0);

    // Flush squashes a stalling load.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 7, 0, 3, 4, 0, 0, 0, 1);
    settle();
    checkOutput("t6_stall", 0, 3'd1, 64'd0, 1'b1);
    applyStimulus(1, 0, 0, 0, 7, 0, 3, 4, 0, 0, 0, 0);
    settle();
    checkOutput("t6_flushed", 0, 3'd0, 64'd3, 1'b0);
`ifdef FWD_HAZARD_STATS_EN
    chk("t6_stall_count", 64'(bus.stall_count), 64'd1);
    chk("t6_fwd_count",   64'(bus.fwd_count),   64'd0);
`endif

    // Hold keeps a stall asserted without advancing.
    applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 9, 9, 1, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 9, 9, 1, 1, 0, 0, 1, 0);
    settle();
    checkOutput("hold_stall", 1, 3'd1, 64'd0, 1'b1);
    applyStimulus(1, 0, 0, 0, 9, 9, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 9, 9, 1, 1, 0, 64'hABC, 0, 0);
    settle();
    checkOutput("hold_release", 1, 3'd2, 64'hABC, 1'b0);

    // Reset sampled in the middle of a stall clears it.
    applyStimulus(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 12, 0, 2, 0, 0, 0, 0, 0);
    settle();
    checkOutput("rst_stall", 0, 3'd1, 64'd0, 1'b1);
    applyStimulus(1, 0, 0, 0, 12, 0, 2, 0, 0, 0, 0, 0);
    settle();
    checkOutput("rst_cleared", 0, 3'd0, 64'd2, 1'b0);

    // Randomized traffic checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(
        ($urandom_range(0, 39) != 0),
        ($urandom_range(0, 3) != 0),
        ($urandom_range(0, 2) == 0),
        pick_reg(), pick_reg(), pick_reg(),
        {$urandom, $urandom}, {$urandom, $urandom},
        {$urandom, $urandom}, {$urandom, $urandom},
        ($urandom_range(0, 7) == 0),
        ($urandom_range(0, 15) == 0)
      );
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
